// File: rtl/tpu_out_collector.sv
// tpu_out_collector: de-skews the bottom-row column stream into a 4x4 tile, accumulates across k-tiles, writes rows out.
// Optional TPU_OUT_SAT_EN makes each lane addition saturate instead of wrap.
module tpu_out_collector #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tile_first,
  input  logic              tile_last,
  input  logic [2:0]        rows,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              col_valid,
  input  logic [WORD_W-1:0] col_data,
  output logic              busy,
  output logic              done,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] index_o,
  output logic [WORD_W-1:0] data_out_o
);
  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;
  state_t state;
  logic first_q, last_q;
  logic [2:0] rows_q, b, r;
  logic [ADDR_W-1:0] base_q;
  logic [3:0][0:3][DATA_W-1:0] acc;
  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] x);
`ifdef TPU_OUT_SAT_EN
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, x};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
    return a + x;
`endif
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      wr_en_o <= 1'b0;
      index_o <= '0;
      data_out_o <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      rows_q <= 3'd4;
      base_q <= '0;
      b <= '0;
      r <= '0;
      acc <= '0;
    end else begin
      // beat b carries row b-c in lane c, so element (i,j) arrives on beat i+j
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (state == CAPTURE && col_valid && b == 3'(i + j))
            acc[i][j] <= lane_add(first_q ? '0 : acc[i][j], col_data[WORD_W-1-j*DATA_W -: DATA_W]);
      case (state)
        IDLE: if (start) begin
          first_q <= tile_first;
          last_q <= tile_last;
          rows_q <= (rows == 3'd0 || rows > 3'd4) ? 3'd4 : rows;
          base_q <= base_addr;
          b <= '0;
          busy <= 1'b1;
          state <= CAPTURE;
        end
        CAPTURE: if (col_valid) begin
          b <= b + 3'd1;
          if (b == 3'd6) begin
            // row 0 is final since beat 3, so its write overlaps the last beat
            if (last_q) begin
              wr_en_o <= 1'b1;
              index_o <= base_q;
              data_out_o <= WORD_W'(acc[0]);
              r <= 3'd1;
              state <= WRITE;
            end else begin
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        WRITE: if (r == rows_q) begin
          wr_en_o <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          index_o <= base_q + ADDR_W'(r);
          data_out_o <= WORD_W'(acc[r[1:0]]);
          r <= r + 3'd1;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_out_collector.sv
// tb_tpu_out_collector: directed tile scenarios with hand-computed row words for tpu_out_collector.
module tb_tpu_out_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, tile_first = 1'b0, tile_last = 1'b0, col_valid = 1'b0;
  logic [2:0] rows = 3'd0;
  logic [7:0] base_addr = 8'd0;
  logic [31:0] col_data = 32'd0;
  logic busy, done, wr_en_o;
  logic [7:0] index_o;
  logic [31:0] data_out_o;
  int nvec = 0, nerr = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, gaps = 0;
  logic bs, busy_after;
  logic [7:0] wi[$];
  logic [31:0] wd[$];
  int wc[$];

  tpu_out_collector dut (
    .clk(clk), .rst(rst), .start(start), .tile_first(tile_first), .tile_last(tile_last),
    .rows(rows), .base_addr(base_addr), .col_valid(col_valid), .col_data(col_data),
    .busy(busy), .done(done), .wr_en_o(wr_en_o), .index_o(index_o), .data_out_o(data_out_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en_o) begin
      wi.push_back(index_o);
      wd.push_back(data_out_o);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] beat_word(input logic [3:0][3:0][7:0] v, input int bt);
    logic [31:0] w;
    for (int c = 0; c < 4; c++)
      w[31-8*c -: 8] = (bt - c >= 0 && bt - c <= 3) ? v[bt-c][c] : 8'hEE;
    return w;
  endfunction

  // called right after a rising edge (+1)
  task automatic run_tile(input logic f, input logic l, input logic [2:0] rw, input logic [7:0] ba,
                          input logic [3:0][3:0][7:0] v, input bit gapped);
    int d0, t, g;
    wi.delete(); wd.delete(); wc.delete();
    d0 = done_cnt; gaps = 0;
    tile_first = f; tile_last = l; rows = rw; base_addr = ba; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_cyc = cyc; bs = busy;
    for (int k = 0; k < 7; k++) begin
      col_valid = 1'b1; col_data = beat_word(v, k);
      @(posedge clk); #1;
      col_valid = 1'b0; col_data = 32'hDEADBEEF;
      g = (gapped && k < 6) ? (k % 3) + 1 : 0;
      gaps += g;
      repeat (g) begin @(posedge clk); #1; end
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
    if (done_cnt == d0) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: done never seen within 200 cycles");
    end
    @(negedge clk); busy_after = busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nvec++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
    nvec++; if (index_o !== 8'h00) begin nerr++; $display("FAIL reset_index: got %h want 00", index_o); end
    nvec++; if (data_out_o !== 32'h0) begin nerr++; $display("FAIL reset_data: got %h want 0", data_out_o); end
  endtask

  task automatic test_single(input bit gapped);
    logic [3:0][3:0][7:0] v;
    logic [31:0] ed[4];
    ed = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v[r][c] = 8'(4*r + c + 1);
    run_tile(1'b1, 1'b1, 3'd4, 8'h10, v, gapped);
    nvec++; if (wi.size() != 4) begin nerr++; $display("FAIL single_count(gap=%0d): got %0d want 4", gapped, wi.size()); end
    for (int i = 0; i < 4 && i < wi.size(); i++) begin
      nvec++; if (wi[i] !== 8'(8'h10 + i)) begin nerr++; $display("FAIL single_index[%0d]: got %h want %h", i, wi[i], 8'(8'h10 + i)); end
      nvec++; if (wd[i] !== ed[i]) begin nerr++; $display("FAIL single_data[%0d]: got %h want %h", i, wd[i], ed[i]); end
      nvec++; if (wc[i] != start_cyc + 7 + gaps + i) begin nerr++; $display("FAIL single_wr_cycle[%0d]: got %0d want %0d", i, wc[i] - start_cyc, 7 + gaps + i); end
    end
    nvec++; if (done_cyc != start_cyc + 11 + gaps) begin nerr++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc - start_cyc, 11 + gaps); end
    nvec++; if (bs !== 1'b1) begin nerr++; $display("FAIL single_busy_rise: got %b want 1", bs); end
    nvec++; if (busy_after !== 1'b0) begin nerr++; $display("FAIL single_busy_fall: got %b want 0", busy_after); end
  endtask

  task automatic test_two_tiles;
    logic [3:0][3:0][7:0] va, vb;
    va = {16{8'h10}}; vb = {16{8'h05}};
    run_tile(1'b1, 1'b0, 3'd4, 8'h20, va, 1'b0);
    nvec++; if (wi.size() != 0) begin nerr++; $display("FAIL twoA_writes: got %0d want 0", wi.size()); end
    nvec++; if (done_cyc != start_cyc + 7) begin nerr++; $display("FAIL twoA_done_cycle: got %0d want 7", done_cyc - start_cyc); end
    col_valid = 1'b1; col_data = 32'h77777777;
    repeat (2) begin @(posedge clk); #1; end
    col_valid = 1'b0;
    run_tile(1'b0, 1'b1, 3'd4, 8'h20, vb, 1'b0);
    nvec++; if (wi.size() != 4) begin nerr++; $display("FAIL twoB_count: got %0d want 4", wi.size()); end
    for (int i = 0; i < wi.size(); i++) begin
      nvec++; if (wd[i] !== 32'h15151515) begin nerr++; $display("FAIL twoB_data[%0d]: got %h want 15151515", i, wd[i]); end
      nvec++; if (wi[i] !== 8'(8'h20 + i)) begin nerr++; $display("FAIL twoB_index[%0d]: got %h want %h", i, wi[i], 8'(8'h20 + i)); end
    end
  endtask

  task automatic test_rows;
    logic [3:0][3:0][7:0] v;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v[r][c] = 8'(4*r + c + 1);
    run_tile(1'b1, 1'b1, 3'd2, 8'hFF, v, 1'b0);
    nvec++; if (wi.size() != 2) begin nerr++; $display("FAIL rows2_count: got %0d want 2", wi.size()); end
    if (wi.size() >= 2) begin
      nvec++; if (wi[0] !== 8'hFF || wd[0] !== 32'h01020304) begin nerr++; $display("FAIL rows2_w0: got %h/%h want ff/01020304", wi[0], wd[0]); end
      nvec++; if (wi[1] !== 8'h00 || wd[1] !== 32'h05060708) begin nerr++; $display("FAIL rows2_w1: got %h/%h want 00/05060708", wi[1], wd[1]); end
    end
    nvec++; if (done_cyc != start_cyc + 9) begin nerr++; $display("FAIL rows2_done_cycle: got %0d want 9", done_cyc - start_cyc); end
    run_tile(1'b1, 1'b1, 3'd0, 8'h40, v, 1'b0);
    nvec++; if (wi.size() != 4) begin nerr++; $display("FAIL rows0_count: got %0d want 4", wi.size()); end
    if (wi.size() == 4) begin
      nvec++; if (wi[3] !== 8'h43 || wd[3] !== 32'h0D0E0F10) begin nerr++; $display("FAIL rows0_w3: got %h/%h want 43/0d0e0f10", wi[3], wd[3]); end
    end
  endtask

  task automatic test_overflow;
    logic [3:0][3:0][7:0] va, vb;
    logic [31:0] exp_w;
`ifdef TPU_OUT_SAT_EN
    exp_w = 32'hFFFFFFFF;
`else
    exp_w = 32'h10101010;
`endif
    va = {16{8'hF0}}; vb = {16{8'h20}};
    run_tile(1'b1, 1'b0, 3'd4, 8'h50, va, 1'b0);
    run_tile(1'b0, 1'b1, 3'd4, 8'h50, vb, 1'b0);
    nvec++; if (wi.size() != 4) begin nerr++; $display("FAIL ovf_count: got %0d want 4", wi.size()); end
    for (int i = 0; i < wi.size(); i++) begin
      nvec++; if (wd[i] !== exp_w) begin nerr++; $display("FAIL ovf_data[%0d]: got %h want %h", i, wd[i], exp_w); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0][3:0][7:0] v, junk;
    logic [31:0] ed[4];
    ed = '{32'h80818283, 32'h84858687, 32'h88898A8B, 32'h8C8D8E8F};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin v[r][c] = 8'(8'h80 + 4*r + c); junk[r][c] = 8'h33; end
    wi.delete();
    tile_first = 1'b1; tile_last = 1'b1; rows = 3'd4; base_addr = 8'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      col_valid = 1'b1; col_data = beat_word(junk, k);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    nvec++; if ({busy, done, wr_en_o} !== 3'b000 || index_o !== 8'h00 || data_out_o !== 32'h0) begin
      nerr++; $display("FAIL midrst_outputs: got busy=%b done=%b wr=%b idx=%h data=%h want all 0", busy, done, wr_en_o, index_o, data_out_o);
    end
    repeat (2) @(negedge clk);
    nvec++; if (busy !== 1'b0 || wi.size() != 0) begin nerr++; $display("FAIL midrst_hold: got busy=%b writes=%0d want 0/0", busy, wi.size()); end
    @(posedge clk); #1;
    rst = 1'b0; col_valid = 1'b0;
    @(posedge clk); #1;
    run_tile(1'b0, 1'b1, 3'd4, 8'h30, v, 1'b0);
    nvec++; if (wi.size() != 4) begin nerr++; $display("FAIL midrst_count: got %0d want 4", wi.size()); end
    for (int i = 0; i < wi.size(); i++) begin
      nvec++; if (wd[i] !== ed[i]) begin nerr++; $display("FAIL midrst_data[%0d]: got %h want %h", i, wd[i], ed[i]); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_single(1'b0);
    test_two_tiles;
    test_single(1'b1);
    test_rows;
    test_overflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
